song_memory: RTL and testbench

- Song storage and playback source that sits on the far side of the player's read interface (read_en / output_ready / data_out).
- A recorder loads note words and durations into it through an append-only write port.
- During playback it steps through the stored song and holds each 10-bit note word on data_out for its recorded duration.
- Word format: [9:2] note keys, [1:0] octave shift.

---
 rtl/song_pkg.sv | 21 ++
 rtl/tick_gen.sv | 34 +++
 rtl/song_memory.sv | 131 +++++++++++++
 tb/tb_song_memory.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared constants and FSM state type for the song storage / playback block.
// Word layout: [9:2] note keys, [1:0] octave shift.
package song_pkg;

  localparam int WORD_W    = 10;
  localparam int NOTE_MSB  = 9;
  localparam int NOTE_LSB  = 2;
  localparam int SHIFT_MSB = 1;
  localparam int SHIFT_LSB = 0;

  localparam int DEF_CLK_HZ  = 100_000_000;
  localparam int DEF_TICK_HZ = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Duration tick generator: one-cycle pulse every CLK_HZ/TICK_HZ cycles,
// phase-aligned to the last cycle in which restart was high.
module tick_gen
  import song_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = !restart && (cnt == CNT_W'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/song_memory.sv
// Append-only song store with looped playback: each note word is held on
// data_out for its duration in ticks, followed by a one-tick silent gap.
module song_memory
  import song_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int DUR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [DUR_W-1:0]  wr_dur,
  output logic              full,
  output logic [ADDR_W:0]   count,
  input  logic              read_en,
  output logic              output_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              song_end,
  output logic [ADDR_W-1:0] rd_index
);

  state_t             state;
  state_t             next_state;
  logic               tick;
  logic               restart;
  logic               wr_accept;
  logic               gap_done;
  logic               last_entry;
  logic [WORD_W-1:0]  word_q;
  logic [DUR_W-1:0]   dur_cnt;

  logic [WORD_W-1:0]  word_mem [DEPTH];
  logic [DUR_W-1:0]   dur_mem  [DEPTH];

  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  assign full       = (count == (ADDR_W + 1)'(DEPTH));
  assign wr_accept  = wr_en && !full && !clear && (state == IDLE);
  assign gap_done   = (state == GAP) && tick;
  assign last_entry = (({1'b0, rd_index} + (ADDR_W + 1)'(1)) == count);
  // Tick phase is pinned while idle/fetching so a note starts on a fresh tick period.
  assign restart    = (state != HOLD) && (state != GAP);

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // NOTE: the note store has no reset; its contents are meaningless once
  // count is cleared, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      word_mem[count[ADDR_W-1:0]] <= wr_data;
      dur_mem[count[ADDR_W-1:0]]  <= wr_dur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every signal driven here gets a default first so no path can
  // infer a latch.
  always_comb begin
    next_state = state;
    if (clear || !read_en) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (count != '0) next_state = FETCH;
        FETCH: next_state = HOLD;
        HOLD:  if (tick && dur_cnt == DUR_W'(1)) next_state = GAP;
        GAP:   if (tick) next_state = FETCH;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    output_ready = 1'b0;
    data_out     = '0;
    unique case (state)
      HOLD: begin
        output_ready = 1'b1;
        data_out     = word_q;
      end
      GAP:     output_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      rd_index <= '0;
      song_end <= 1'b0;
      word_q   <= '0;
      dur_cnt  <= '0;
    end else begin
      if (clear)          count <= '0;
      else if (wr_accept) count <= count + 1'b1;

      if (next_state == IDLE) rd_index <= '0;
      else if (gap_done)      rd_index <= last_entry ? '0 : rd_index + 1'b1;

      song_end <= gap_done && last_entry && (next_state != IDLE);

      // Single registered read: word and duration of the entry at rd_index.
      if (state == FETCH) begin
        word_q  <= word_mem[rd_index];
        dur_cnt <= eff_dur(dur_mem[rd_index]);
      end else if (state == HOLD && tick) begin
        dur_cnt <= dur_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_song_memory.sv
// Self-checking bench for song_memory: a note-list model expands each song
// into its expected per-cycle output timeline.
module tb_song_memory;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int TICK    = CLK_HZ / TICK_HZ;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int DUR_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              wr_en = 1'b0;
  logic [9:0]        wr_data = '0;
  logic [DUR_W-1:0]  wr_dur = '0;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              read_en = 1'b0;
  logic              output_ready;
  logic [9:0]        data_out;
  logic              song_end;
  logic [ADDR_W-1:0] rd_index;

  int n_cmp = 0;
  int n_err = 0;

  song_memory #(
    .CLK_HZ (CLK_HZ), .TICK_HZ (TICK_HZ), .DEPTH (DEPTH),
    .ADDR_W (ADDR_W), .DUR_W (DUR_W)
  ) dut (
    .clk (clk), .rst_n (rst_n), .clear (clear), .wr_en (wr_en),
    .wr_data (wr_data), .wr_dur (wr_dur), .full (full), .count (count),
    .read_en (read_en), .output_ready (output_ready), .data_out (data_out),
    .song_end (song_end), .rd_index (rd_index)
  );

  always #5 clk = ~clk;

  // Reference model: the stored song as a plain list of notes.
  logic [9:0] m_word[$];
  int         m_dur[$];

  typedef struct {
    logic       rdy;
    logic [9:0] dat;
    int         idx;
    logic       se;
  } exp_t;
  exp_t exp_q[$];

  // Timeline after read_en is sampled: one fetch cycle, then per note
  // dur*TICK cycles of the word, TICK cycles of silence, one fetch cycle.
  task automatic build_exp(input int ncyc);
    int n, i, ticks;
    n = m_word.size();
    exp_q.delete();
    exp_q.push_back('{1'b0, 10'h0, 0, 1'b0});
    i = 0;
    while (exp_q.size() < ncyc) begin
      ticks = (m_dur[i] == 0) ? 1 : m_dur[i];
      for (int k = 0; k < ticks * TICK; k++) exp_q.push_back('{1'b1, m_word[i], i, 1'b0});
      for (int k = 0; k < TICK; k++)         exp_q.push_back('{1'b1, 10'h0, i, 1'b0});
      exp_q.push_back('{1'b0, 10'h0, (i + 1) % n, (i == n - 1)});
      i = (i + 1) % n;
    end
  endtask

  task automatic write_entry(input logic [9:0] w, input int d);
    wr_en = 1'b1; wr_data = w; wr_dur = DUR_W'(d);
    @(negedge clk);
    wr_en = 1'b0;
    if (m_word.size() < DEPTH && !read_en) begin
      m_word.push_back(w);
      m_dur.push_back(d);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_word.delete();
    m_dur.delete();
  endtask

  task automatic check_count(input string name);
    n_cmp++;
    if (count !== (ADDR_W + 1)'(m_word.size()) || full !== (m_word.size() == DEPTH)) begin
      n_err++;
      $display("FAIL %s: count=%0d full=%0b, required count=%0d full=%0b",
               name, count, full, m_word.size(), (m_word.size() == DEPTH));
    end
  endtask

  // Raises read_en and compares ncyc cycles against the model; leaves read_en high.
  task automatic play_check(input string name, input int ncyc);
    build_exp(ncyc);
    read_en = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      n_cmp++;
      if (output_ready !== exp_q[c].rdy || data_out !== exp_q[c].dat ||
          int'(rd_index) !== exp_q[c].idx || song_end !== exp_q[c].se) begin
        n_err++;
        $display("FAIL %s cyc %0d: rdy=%0b data=%h idx=%0d end=%0b, required rdy=%0b data=%h idx=%0d end=%0b",
                 name, c, output_ready, data_out, rd_index, song_end,
                 exp_q[c].rdy, exp_q[c].dat, exp_q[c].idx, exp_q[c].se);
      end
    end
  endtask

  task automatic stop_play();
    read_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_count("reset_count");
    n_cmp++;
    if (output_ready !== 1'b0 || data_out !== 10'h0 || song_end !== 1'b0 || rd_index !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%0b data=%h end=%0b idx=%0d, required all 0",
               output_ready, data_out, song_end, rd_index);
    end
  endtask

  task automatic test_empty_read();
    read_en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_cmp++;
      if (output_ready !== 1'b0 || data_out !== 10'h0) begin
        n_err++;
        $display("FAIL empty_read cyc %0d: rdy=%0b data=%h, required rdy=0 data=000",
                 c, output_ready, data_out);
      end
    end
    stop_play();
  endtask

  task automatic test_two_notes();
    write_entry(10'h0C1, 2);
    write_entry(10'h302, 1);
    check_count("two_notes_count");
    play_check("two_notes", 1 + 52 + 30);
    stop_play();
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < 5; i++) write_entry(10'($urandom), $urandom_range(0, 3));
    check_count("full_after_5");
    play_check("full_play", 15);
    wr_en = 1'b1; wr_data = 10'h3FF; wr_dur = 8'd1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check_count("write_while_playing");
    stop_play();
  endtask

  task automatic test_read_drop();
    int d0;
    d0 = (m_dur[0] == 0) ? 1 : m_dur[0];
    play_check("drop_pre", 1 + d0 * TICK + TICK + 1 + 5);
    read_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (output_ready !== 1'b0 || data_out !== 10'h0 || rd_index !== '0) begin
      n_err++;
      $display("FAIL read_drop: rdy=%0b data=%h idx=%0d, required rdy=0 data=000 idx=0",
               output_ready, data_out, rd_index);
    end
    play_check("drop_restart", 40);
    stop_play();
  endtask

  task automatic test_clear_write();
    play_check("clear_pre", 25);
    clear = 1'b1; wr_en = 1'b1; wr_data = 10'($urandom); wr_dur = 8'd2;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    m_word.delete(); m_dur.delete();
    check_count("clear_count");
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (output_ready !== 1'b0 || data_out !== 10'h0) begin
        n_err++;
        $display("FAIL clear_idle cyc %0d: rdy=%0b data=%h, required rdy=0 data=000",
                 c, output_ready, data_out);
      end
      @(negedge clk);
    end
    stop_play();
  endtask

  task automatic test_random();
    int n, len;
    for (int r = 0; r < 4; r++) begin
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) write_entry(10'($urandom), $urandom_range(0, 3));
      check_count("random_count");
      len = 1;
      for (int i = 0; i < n; i++) len += ((m_dur[i] == 0) ? 1 : m_dur[i]) * TICK + TICK + 1;
      play_check("random_play", len + 25);
      stop_play();
    end
  endtask

  task automatic test_async_reset();
    play_check("arst_pre", 8);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (output_ready !== 1'b0 || data_out !== 10'h0) begin
      n_err++;
      $display("FAIL async_reset: rdy=%0b data=%h, required rdy=0 data=000",
               output_ready, data_out);
    end
    read_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_word.delete(); m_dur.delete();
    @(negedge clk);
    check_count("async_reset_count");
  endtask

  initial begin
    test_reset();
    test_empty_read();
    test_two_notes();
    test_full();
    test_read_drop();
    test_clear_write();
    test_random();
    do_clear();
    write_entry(10'h1A5, 3);
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
